// File: rtl/nco_phase_gen.sv
// Phase-word source for the nco angle input: accumulates a tuning step (with optional
// linear chirp), adds a phase offset and presents the result on a req/ack handshake.
module nco_phase_gen #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned STEP_W  = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [STEP_W-1:0]  cfg_step,
  input  logic [STEP_W-1:0]  cfg_stop_step,
  input  logic [STEP_W-1:0]  cfg_delta,
  input  logic [PHASE_W-1:0] cfg_offset,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_burst_len,
  input  logic               start,
  input  logic               stop,
  output logic [PHASE_W-1:0] t_angle_dat,
  output logic               t_angle_req,
  input  logic               t_angle_ack,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_REPEAT = 2'd2;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [PHASE_W-1:0] dat_q, dat_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [STEP_W-1:0]  start_step_q, stop_step_q, delta_q;
  logic [PHASE_W-1:0] offset_q;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   burst_len_q;

  logic               load_c;
  logic               xfer_c;
  logic [PHASE_W-1:0] phase_sum_c;
  logic [STEP_W:0]    step_ext_c;
  logic [STEP_W-1:0]  step_add_c;
  logic               crossed_c;
  logic [STEP_W-1:0]  step_chirp_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               burst_end_c;

  assign t_angle_dat = dat_q;
  assign t_angle_req = req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sample_cnt  = cnt_q;

  // Datapath helpers: next phase, chirped step and limit detection.
  // The extra carry bit treats wrap past zero / all-ones as crossing the limit,
  // so a negative sweep toward a small stop_step cannot wrap to a huge step.
  always_comb begin
    xfer_c      = req_q & t_angle_ack;
    phase_sum_c = phase_q + step_q;
    step_ext_c  = {1'b0, step_q} + {1'b0, delta_q};
    step_add_c  = step_ext_c[STEP_W-1:0];
    crossed_c   = 1'b0;
    if (delta_q != '0) begin
      if (delta_q[STEP_W-1]) begin
        crossed_c = !step_ext_c[STEP_W] || (step_add_c < stop_step_q);
      end else begin
        crossed_c = step_ext_c[STEP_W] || (step_add_c > stop_step_q);
      end
    end
    case (mode_q)
      MODE_SINGLE: step_chirp_c = crossed_c ? stop_step_q : step_add_c;
      MODE_REPEAT: step_chirp_c = crossed_c ? start_step_q : step_add_c;
      default:     step_chirp_c = step_q;
    endcase
    cnt_inc_c   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    burst_end_c = (burst_len_q != '0) && (cnt_inc_c == burst_len_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = step_q;
    dat_d   = dat_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          load_c  = 1'b1;
          phase_d = '0;
          step_d  = cfg_step;
          cnt_d   = '0;
          dat_d   = cfg_offset;
          req_d   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_STOPPING: begin
        if (xfer_c) begin
          phase_d = phase_sum_c;
          step_d  = step_chirp_c;
          cnt_d   = cnt_inc_c;
          dat_d   = phase_sum_c + offset_q;
          if (stop || burst_end_c || state_q == ST_STOPPING) begin
            req_d   = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (stop && state_q == ST_RUN) begin
          state_d = ST_STOPPING;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      step_q  <= '0;
      dat_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      dat_q   <= dat_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shadow configuration, captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start_step_q <= '0;
      stop_step_q  <= '0;
      delta_q      <= '0;
      offset_q     <= '0;
      mode_q       <= '0;
      burst_len_q  <= '0;
    end else if (load_c) begin
      start_step_q <= cfg_step;
      stop_step_q  <= cfg_stop_step;
      delta_q      <= cfg_delta;
      offset_q     <= cfg_offset;
      mode_q       <= cfg_mode;
      burst_len_q  <= cfg_burst_len;
    end
  end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed self-checking bench for nco_phase_gen.
module tb_nco_phase_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cfg_step, cfg_stop_step, cfg_delta, cfg_offset;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_burst_len;
  logic        start, stop, t_angle_ack;
  logic [31:0] t_angle_dat;
  logic        t_angle_req, busy, done;
  logic [15:0] sample_cnt;

  int checks   = 0;
  int failures = 0;

  nco_phase_gen dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_step      (cfg_step),
    .cfg_stop_step (cfg_stop_step),
    .cfg_delta     (cfg_delta),
    .cfg_offset    (cfg_offset),
    .cfg_mode      (cfg_mode),
    .cfg_burst_len (cfg_burst_len),
    .start         (start),
    .stop          (stop),
    .t_angle_dat   (t_angle_dat),
    .t_angle_req   (t_angle_req),
    .t_angle_ack   (t_angle_ack),
    .busy          (busy),
    .done          (done),
    .sample_cnt    (sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stop_now();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  logic [31:0] k;
  logic [31:0] exp_ph [7];

  initial begin
    reset_n = 1'b0;
    cfg_step = '0; cfg_stop_step = '0; cfg_delta = '0; cfg_offset = '0;
    cfg_mode = '0; cfg_burst_len = '0;
    start = 1'b0; stop = 1'b0; t_angle_ack = 1'b0;
    tick(); tick();
    check("rst_dat", t_angle_dat, 32'h0);
    check("rst_req", 32'(t_angle_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_cnt", 32'(sample_cnt), 32'h0);
    reset_n = 1'b1;
    tick();

    // Tone with wrap after 16 samples
    cfg_step = 32'h1000_0000; cfg_offset = 32'h0000_0100; cfg_mode = 2'd0;
    t_angle_ack = 1'b1;
    pulse_start();
    check("tone_busy", 32'(busy), 32'h1);
    for (int i = 0; i <= 16; i++) begin
      check("tone_req", 32'(t_angle_req), 32'h1);
      check("tone_dat", t_angle_dat, 32'(i) * 32'h1000_0000 + 32'h100);
      tick();
    end
    stop_now();
    check("tone_stop_req", 32'(t_angle_req), 32'h0);
    check("tone_stop_done", 32'(done), 32'h1);
    check("tone_stop_busy", 32'(busy), 32'h0);
    check("tone_cnt", 32'(sample_cnt), 32'd18);
    tick();
    check("tone_done_pulse", 32'(done), 32'h0);
    check("tone_cnt_hold", 32'(sample_cnt), 32'd18);

    // Backpressure: same tone with random ack
    k = 0;
    t_angle_ack = 1'b0;
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      check("bp_req", 32'(t_angle_req), 32'h1);
      check("bp_dat", t_angle_dat, k * 32'h1000_0000 + 32'h100);
      t_angle_ack = 1'($urandom_range(0, 1));
      tick();
      if (t_angle_ack) k = k + 1;
    end
    t_angle_ack = 1'b0;
    stop_now();
    check("stopping_busy", 32'(busy), 32'h1);
    check("stopping_req", 32'(t_angle_req), 32'h1);
    check("stopping_dat", t_angle_dat, k * 32'h1000_0000 + 32'h100);
    check("stopping_done", 32'(done), 32'h0);
    tick();
    check("stopping_hold_req", 32'(t_angle_req), 32'h1);
    t_angle_ack = 1'b1;
    tick();
    t_angle_ack = 1'b0;
    check("stopped_req", 32'(t_angle_req), 32'h0);
    check("stopped_done", 32'(done), 32'h1);
    check("stopped_busy", 32'(busy), 32'h0);
    check("stopped_cnt", 32'(sample_cnt), k + 1);
    tick();

    // Single sweep, step clamps at 40; cfg change mid-run must be ignored
    cfg_step = 32'd10; cfg_stop_step = 32'd40; cfg_delta = 32'd10;
    cfg_offset = 32'h0; cfg_mode = 2'd1;
    exp_ph[0] = 0; exp_ph[1] = 10; exp_ph[2] = 30; exp_ph[3] = 60;
    exp_ph[4] = 100; exp_ph[5] = 140; exp_ph[6] = 180;
    t_angle_ack = 1'b1;
    pulse_start();
    cfg_step = 32'd999; cfg_offset = 32'd5; cfg_delta = 32'd1;
    for (int i = 0; i < 7; i++) begin
      check("sweep1_dat", t_angle_dat, exp_ph[i]);
      tick();
    end
    stop_now();
    tick();

    // Repeat sweep, negative delta: steps 40,25,10,40,25,10
    cfg_step = 32'd40; cfg_stop_step = 32'd10; cfg_delta = 32'hFFFF_FFF1;
    cfg_offset = 32'h0; cfg_mode = 2'd2;
    exp_ph[0] = 0; exp_ph[1] = 40; exp_ph[2] = 65; exp_ph[3] = 75;
    exp_ph[4] = 115; exp_ph[5] = 140; exp_ph[6] = 150;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      check("sweep2_dat", t_angle_dat, exp_ph[i]);
      tick();
    end
    stop_now();
    tick();

    // Burst of 5
    cfg_step = 32'd1; cfg_delta = 32'h0; cfg_mode = 2'd0; cfg_burst_len = 16'd5;
    pulse_start();
    cfg_burst_len = 16'd0;
    for (int i = 0; i < 5; i++) begin
      check("burst_req", 32'(t_angle_req), 32'h1);
      check("burst_dat", t_angle_dat, 32'(i));
      check("burst_no_done", 32'(done), 32'h0);
      tick();
    end
    check("burst_end_req", 32'(t_angle_req), 32'h0);
    check("burst_end_done", 32'(done), 32'h1);
    check("burst_end_busy", 32'(busy), 32'h0);
    check("burst_end_cnt", 32'(sample_cnt), 32'd5);
    tick();
    check("burst_done_once", 32'(done), 32'h0);
    check("burst_cnt_hold", 32'(sample_cnt), 32'd5);
    check("burst_idle_req", 32'(t_angle_req), 32'h0);

    // Reset mid-run
    cfg_step = 32'h1000_0000; cfg_offset = 32'h100;
    pulse_start();
    tick(); tick(); tick();
    reset_n = 1'b0;
    tick();
    check("midrst_dat", t_angle_dat, 32'h0);
    check("midrst_req", 32'(t_angle_req), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_cnt", 32'(sample_cnt), 32'h0);
    reset_n = 1'b1;
    tick();

    // start together with stop in IDLE does nothing
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 32'h0);
    check("ss_req", 32'(t_angle_req), 32'h0);
    tick();
    check("ss_done", 32'(done), 32'h0);
    check("ss_busy2", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
